// File: rtl/hazard_scoreboard.sv
// Pipelines register indices and write/branch controls through E, M and W,
// producing the forwarding compares, the load-use compare and a stall counter.
module hazard_scoreboard #(
   parameter int REGW = 4,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [REGW-1:0] RA1D,
   input  logic [REGW-1:0] RA2D,
   input  logic [REGW-1:0] RA3D,
   input  logic [REGW-1:0] RA0D,
   input  logic            UseAD,
   input  logic            UseBD,
   input  logic            UseCD,
   input  logic            UseDD,
   input  logic [REGW-1:0] WA3D,
   input  logic [REGW-1:0] WA2D,
   input  logic            RegWriteD,
   input  logic            RegWrite2D,
   input  logic            MemToRegD,
   input  logic            PCSrcD,
   input  logic            CondExE,
   input  logic            FlushE,
   output logic            Match_1E_M,
   output logic            Match_1E_W,
   output logic            Match_1E_M0,
   output logic            Match_1E_W0,
   output logic            Match_2E_M,
   output logic            Match_2E_W,
   output logic            Match_2E_M0,
   output logic            Match_2E_W0,
   output logic            Match_3E_M,
   output logic            Match_3E_W,
   output logic            Match_3E_M0,
   output logic            Match_3E_W0,
   output logic            Match_0E_M,
   output logic            Match_0E_W,
   output logic            Match_0E_M0,
   output logic            Match_0E_W0,
   output logic            Match_12D_E,
   output logic            RegWriteM,
   output logic            RegWriteW,
   output logic            RegWrite2M,
   output logic            RegWrite2W,
   output logic            MemToRegE,
   output logic            PCSrcE,
   output logic            PCSrcM,
   output logic            PCSrcW,
   output logic [CNTW-1:0] LoadStallCnt
);

   localparam logic [REGW-1:0] PC_IDX = '1;

   // Operand slots are ordered 3=C, 2=B, 1=A, 0=D to follow the RAk numbering.
   logic [3:0][REGW-1:0] ra_e_q, ra_e_d;
   logic [3:0]           use_e_q, use_e_d;
   logic [REGW-1:0]      wa3_e_q, wa3_e_d, wa2_e_q, wa2_e_d;
   logic                 rw_e_q, rw_e_d, rw2_e_q, rw2_e_d;
   logic                 mtr_e_q, mtr_e_d, pcs_e_q, pcs_e_d;

   logic [REGW-1:0]      wa3_m_q, wa2_m_q, wa3_w_q, wa2_w_q;
   logic                 rw_m_q, rw2_m_q, pcs_m_q;
   logic                 rw_w_q, rw2_w_q, pcs_w_q;
   logic [CNTW-1:0]      cnt_q, cnt_d;

   logic [3:0]           m_m, m_w, m_m0, m_w0;
   logic                 load_use;

   always_comb begin
      ra_e_d  = {RA3D, RA2D, RA1D, RA0D};
      use_e_d = {UseCD, UseBD, UseAD, UseDD};
      wa3_e_d = WA3D;
      wa2_e_d = WA2D;
      rw_e_d  = RegWriteD;
      rw2_e_d = RegWrite2D;
      mtr_e_d = MemToRegD;
      pcs_e_d = PCSrcD;
      if (FlushE) begin
         ra_e_d  = '0;
         use_e_d = '0;
         wa3_e_d = '0;
         wa2_e_d = '0;
         rw_e_d  = 1'b0;
         rw2_e_d = 1'b0;
         mtr_e_d = 1'b0;
         pcs_e_d = 1'b0;
      end
   end

   assign load_use = ((UseAD && (RA1D == wa3_e_q) && (RA1D != PC_IDX)) ||
                      (UseBD && (RA2D == wa3_e_q) && (RA2D != PC_IDX))) && rw_e_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_use && mtr_e_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ra_e_q  <= '0;
         use_e_q <= '0;
         wa3_e_q <= '0;
         wa2_e_q <= '0;
         rw_e_q  <= 1'b0;
         rw2_e_q <= 1'b0;
         mtr_e_q <= 1'b0;
         pcs_e_q <= 1'b0;
         wa3_m_q <= '0;
         wa2_m_q <= '0;
         rw_m_q  <= 1'b0;
         rw2_m_q <= 1'b0;
         pcs_m_q <= 1'b0;
         wa3_w_q <= '0;
         wa2_w_q <= '0;
         rw_w_q  <= 1'b0;
         rw2_w_q <= 1'b0;
         pcs_w_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ra_e_q  <= ra_e_d;
         use_e_q <= use_e_d;
         wa3_e_q <= wa3_e_d;
         wa2_e_q <= wa2_e_d;
         rw_e_q  <= rw_e_d;
         rw2_e_q <= rw2_e_d;
         mtr_e_q <= mtr_e_d;
         pcs_e_q <= pcs_e_d;
         // A failed condition cancels the writes and branch as E retires.
         wa3_m_q <= wa3_e_q;
         wa2_m_q <= wa2_e_q;
         rw_m_q  <= rw_e_q & CondExE;
         rw2_m_q <= rw2_e_q & CondExE;
         pcs_m_q <= pcs_e_q & CondExE;
         wa3_w_q <= wa3_m_q;
         wa2_w_q <= wa2_m_q;
         rw_w_q  <= rw_m_q;
         rw2_w_q <= rw2_m_q;
         pcs_w_q <= pcs_m_q;
         cnt_q   <= cnt_d;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_match
         logic valid;
         assign valid     = use_e_q[gi] && (ra_e_q[gi] != PC_IDX);
         assign m_m[gi]   = valid && (ra_e_q[gi] == wa3_m_q);
         assign m_w[gi]   = valid && (ra_e_q[gi] == wa3_w_q);
         assign m_m0[gi]  = valid && (ra_e_q[gi] == wa2_m_q);
         assign m_w0[gi]  = valid && (ra_e_q[gi] == wa2_w_q);
      end
   endgenerate

   assign Match_1E_M  = m_m[1];
   assign Match_1E_W  = m_w[1];
   assign Match_1E_M0 = m_m0[1];
   assign Match_1E_W0 = m_w0[1];
   assign Match_2E_M  = m_m[2];
   assign Match_2E_W  = m_w[2];
   assign Match_2E_M0 = m_m0[2];
   assign Match_2E_W0 = m_w0[2];
   assign Match_3E_M  = m_m[3];
   assign Match_3E_W  = m_w[3];
   assign Match_3E_M0 = m_m0[3];
   assign Match_3E_W0 = m_w0[3];
   assign Match_0E_M  = m_m[0];
   assign Match_0E_W  = m_w[0];
   assign Match_0E_M0 = m_m0[0];
   assign Match_0E_W0 = m_w0[0];

   assign Match_12D_E  = load_use;
   assign RegWriteM    = rw_m_q;
   assign RegWriteW    = rw_w_q;
   assign RegWrite2M   = rw2_m_q;
   assign RegWrite2W   = rw2_w_q;
   assign MemToRegE    = mtr_e_q;
   assign PCSrcE       = pcs_e_q;
   assign PCSrcM       = pcs_m_q;
   assign PCSrcW       = pcs_w_q;
   assign LoadStallCnt = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer side of the forwarding/stall handshake. Tracks source and destination register indices and the write/branch control bits of each in-flight instruction through the E, M and W pipeline registers. From them it generates every `Match_*` comparison, the pipelined `RegWrite*`, `MemToRegE` and `PCSrc*` bits that the hazard unit consumes. It also counts load-use stall cycles. It sits between the decoder/condition unit and the hazard unit, and honours the hazard unit's `FlushE` as its only pipeline-control input.

## Interface
- `REGW`, default 4: register index width.
- `CNTW`, default 16: load-stall counter width.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low (0 = reset).
- `RA1D`, `RA2D`, `RA3D`, `RA0D` input, REGW each: decode-stage source indices for operands A, B, C, D.
- `UseAD`, `UseBD`, `UseCD`, `UseDD` input, 1 bit each: the matching operand is actually read.
- `WA3D`, `WA2D` input, REGW each: primary and secondary destination indices.
- `RegWriteD`, `RegWrite2D`, `MemToRegD`, `PCSrcD` input, 1 bit each: decoded controls.
- `CondExE` input, 1 bit: the E-stage instruction passed its condition check.
- `FlushE` input, 1 bit: load a bubble into E this edge.
- `Match_{1,2,3,0}E_{M,W,M0,W0}` output, 1 bit each (16 total): operand-versus-destination matches.
- `Match_12D_E` output, 1 bit: the D-stage A or B source equals the E-stage primary destination.
- `RegWriteM`, `RegWriteW`, `RegWrite2M`, `RegWrite2W`, `MemToRegE`, `PCSrcE`, `PCSrcM`, `PCSrcW` output, 1 bit each.
- `LoadStallCnt` output, CNTW bits: saturating count of load-use stall cycles.

## Operation
- **E register.** Loads every edge. It holds RA1..RA0, Use*, WA3, WA2, RegWrite, RegWrite2, MemToReg and PCSrc.
  - `FlushE`=1: E loads a bubble. All control bits and Use flags are 0, and all indices are 0.
- **M register.** Loads every edge from E.
  - `RegWriteM` = RegWriteE & CondExE.
  - `RegWrite2M` = RegWrite2E & CondExE.
  - `PCSrcM` = PCSrcE & CondExE.
  - WA3M and WA2M are copied unconditionally.
- **W register.** Loads every edge from M, unchanged.
- **Operand matches.** For operand k (1=A, 2=B, 3=C, 0=D), each match requires `UseE[k]` and `RAkE != 4'hF`:
  - `Match_kE_M` = (RAkE == WA3M).
  - `Match_kE_W` = (RAkE == WA3W).
  - `Match_kE_M0` = (RAkE == WA2M).
  - `Match_kE_W0` = (RAkE == WA2W).
  - The write-enable qualification is done in the hazard unit; the raw index compare is output here.
- **Load-use match.** `Match_12D_E` = ((UseAD & RA1D==WA3E & RA1D!=15) | (UseBD & RA2D==WA3E & RA2D!=15)) & RegWriteE.
- **Counter.** `LoadStallCnt` increments when `Match_12D_E & MemToRegE` is 1 at a rising edge. It saturates at all-ones and is cleared only by reset.
- **Reset.** While `reset`=0:
  - Every register and the counter are 0.
  - Therefore all Match outputs, RegWrite/PCSrc/MemToReg outputs and `LoadStallCnt` read 0.
  - Reset asserted mid-operation discards all in-flight state within the same cycle, with no clock required.

## Timing
- All outputs except `Match_12D_E` are combinational from registered state only: no D-input-to-output path.
- `Match_12D_E` is combinational from the D inputs plus E state. Its settle time is one comparator plus an AND/OR level.
- A D-stage instruction reaches E 1 edge later, M 2 edges later and W 3 edges later, unless it is flushed into E.
- A load-use stall is sequenced as follows:
  - The hazard unit raises `FlushE`.
  - The E bubble appears after 1 edge.
  - The held D instruction re-presents; with `RegWriteE`=0, `Match_12D_E` drops the following cycle.
- `FlushE` with a valid D instruction: flush wins and that instruction never enters E. The decoder re-presents it under the hazard unit's hold.
- `CondExE`=0 kills writes and PCSrc at the E-to-M edge only. `MemToRegE` and the E-stage match outputs are unaffected that cycle.
- Counter saturation: at all-ones with a stall condition present, the value is held with no wrap.

## Test plan
- **Reset.** Drive `reset`=0 mid-stream with nonzero state -> all outputs 0 immediately. After release, the first instruction appears in E one edge later.
- **Back-to-back ALU forwarding.**
  - Stimulus: instruction 1 writes R3 (WA3D=3, RegWriteD=1); instruction 2 reads R3 on A (RA1D=3, UseAD=1).
  - Required: on the cycle instruction 2 is in E, `Match_1E_M`=1 and `RegWriteM`=1. One edge later `Match_1E_W`=1 if instruction 2 is held, else it is gone.
- **Secondary destination.** Instruction 1 with WA2D=5, RegWrite2D=1, followed by an instruction reading R5 on operand D -> `Match_0E_M0`=1 and `RegWrite2M`=1. `Match_0E_M`=0 when WA3D≠5.
- **Load-use.**
  - Stimulus: LDR writing R2 (MemToRegD=1); next instruction reads R2 on B.
  - Required: `Match_12D_E`=1 and `MemToRegE`=1 for one cycle, and `LoadStallCnt` goes 0->1. Asserting `FlushE` clears `RegWriteE` next edge, and `Match_12D_E` returns to 0.
- **Condition fail and R15.**
  - Stimulus: CondExE=0 on a writer of R4 with PCSrcE=1.
  - Required: `RegWriteM`=0 and `PCSrcM`=0 next edge. A source RA1=15 never matches, even with WA3M=15.
- **Counter saturation.** Preset by running 2^CNTW stall cycles with `CNTW` overridden to 4 -> the counter stops at 15 and does not wrap.
